imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Writer side of the instruction memory: receives a program as a byte stream over a valid/ready handshake.
- Assembles bytes into little-endian 32-bit instruction words and drives the memory's synchronous write port at word-aligned byte addresses.
- Holds the pipeline (cpu_hold) for the whole load, so the core only fetches from instruction memory after the program is complete.

Parameters:
- DEPTH, 64, number of 32-bit instruction words in instruction memory.
- LEN_W, 7, width of len_words; must be clog2(DEPTH)+1.

Ports:
- clk  in  1  system clock, rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request a new load; sampled only in IDLE.
- len_words  in  LEN_W  number of words to load; sampled with start.
- in_valid  in  1  byte stream valid.
- in_data  in  8  byte stream data.
- in_ready  out  1  loader accepts a byte this cycle.
- we  out  1  instruction memory write enable, 1-cycle pulse per word.
- waddr  out  32  byte address of the word being written (word_idx*4).
- wdata  out  32  assembled instruction word.
- busy  out  1  load in progress.
- done  out  1  1-cycle pulse when the last word has been written.
- err  out  1  sticky: last start had an illegal length.
- cpu_hold  out  1  stall/hold request to the pipeline during load.

Behaviour:
- Reset (rst_n low, asynchronous):
  - State goes to IDLE.
  - byte_cnt, word_idx and the assembly register clear.
  - All outputs read 0: in_ready, we, waddr, wdata, busy, done, err, cpu_hold.
  - Reset mid-load abandons the load; words already written stay in memory.
- States: IDLE, LOAD, WRITE, DONE.
- IDLE:
  - in_ready=0, busy=0, cpu_hold=0.
  - start with 1 <= len_words <= DEPTH: latch the length, clear counters, clear err, go to LOAD.
  - start with len_words=0 or len_words>DEPTH: set err=1, stay in IDLE.
- LOAD:
  - in_ready=1, busy=1, cpu_hold=1.
  - A byte transfers when in_valid && in_ready. Byte k (k=0..3) goes to assembly bits [8k+7:8k] (little-endian).
  - byte_cnt increments per accepted byte.
  - On the 4th byte (byte_cnt==3 and transfer): byte_cnt returns to 0, next state WRITE.
  - in_valid low keeps the state unchanged; there is no timeout.
- WRITE:
  - Lasts exactly 1 cycle: we=1, waddr={word_idx,2'b00} zero-extended to 32 bits, wdata=assembled word.
  - in_ready=0 (no byte is accepted in this cycle).
  - If word_idx == len-1, next state is DONE; otherwise word_idx increments and next state is LOAD.
- DONE: lasts 1 cycle with done=1, busy=1, cpu_hold=1; next state IDLE, where cpu_hold drops.
- Output timing:
  - we, waddr and wdata are registered.
  - waddr and wdata hold their last value outside WRITE. Only we qualifies them.
- start outside IDLE is ignored (no restart, err unaffected).
- Throughput: at most 1 word per 5 cycles (4 byte cycles + 1 WRITE).
- First we occurs 1 cycle after the 4th byte handshake.
- word_idx never exceeds DEPTH-1, so the last legal waddr is (DEPTH-1)*4.
- cpu_hold rises in the cycle after start is accepted and falls in the cycle after done.

Test Plan:
- Basic load: start, len_words=2, stream 13 00 00 00 B3 00 50 00 with in_valid held high.
  -> we pulses with waddr=0x0 / wdata=0x00000013, then waddr=0x4 / wdata=0x005000B3.
  -> done=1 the cycle after the second we; cpu_hold low the following cycle.
- Backpressure gaps: as the basic load, but in_valid drops for 3 cycles between every byte.
  -> Identical writes; no byte is lost or duplicated.
  -> in_ready=0 during each WRITE cycle.
- Illegal length, 0: len_words=0 -> err=1, state stays IDLE, in_ready stays 0.
- Illegal length, 65: len_words=65 -> err=1.
- Recovery from err: a following legal start clears err and the load proceeds normally.
- Full depth: len_words=64, 256 bytes of pattern byte = index mod 256.
  -> 64 we pulses; last waddr=0xFC, wdata=0xFFFEFDFC.
  -> Exactly one done pulse.
- Start mid-load and reset mid-load:
  - start asserted with len_words=1 in the middle of a 3-word load -> ignored; 3 words written.
  - rst_n low after 6 bytes -> all outputs 0 immediately.
  - Next start with len_words=1 and bytes 33 00 00 00 -> writes waddr=0x0, wdata=0x00000033.

Source files
------------

// File: rtl/imem_loader.sv
// Instruction memory loader: takes a program as a byte stream over a
// valid/ready handshake, packs each group of four bytes into one
// little-endian 32-bit word, and writes it to instruction memory at a
// word-aligned byte address. The pipeline is held for the whole load.
module imem_loader #(
    parameter int DEPTH = 64,
    parameter int LEN_W = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] len_words,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    output logic             in_ready,
    output logic             we,
    output logic [31:0]      waddr,
    output logic [31:0]      wdata,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             cpu_hold
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [1:0]       byte_cnt_q, byte_cnt_d;
    logic [IDX_W-1:0] word_idx_q, word_idx_d;
    // Only the first three bytes need storage; the fourth goes straight
    // into the output word in the same cycle it arrives.
    logic [23:0]      asm_q, asm_d;
    logic             we_q, we_d;
    logic [31:0]      waddr_q, waddr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic             err_q, err_d;

    logic len_ok;
    logic xfer;
    logic last_word;

    assign len_ok    = (len_words != '0) && (len_words <= LEN_W'(DEPTH));
    assign xfer      = in_valid && (state_q == ST_LOAD);
    assign last_word = (LEN_W'(word_idx_q) == (len_q - LEN_W'(1)));

    // Next-state and datapath update for the load sequence.
    always_comb begin
        // NOTE: every signal gets a default here so no path leaves one
        // unassigned, which would otherwise infer a latch.
        state_d    = state_q;
        len_d      = len_q;
        byte_cnt_d = byte_cnt_q;
        word_idx_d = word_idx_q;
        asm_d      = asm_q;
        we_d       = 1'b0;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        err_d      = err_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (len_ok) begin
                        len_d      = len_words;
                        byte_cnt_d = '0;
                        word_idx_d = '0;
                        err_d      = 1'b0;
                        state_d    = ST_LOAD;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end

            ST_LOAD: begin
                if (xfer) begin
                    if (byte_cnt_q == 2'd3) begin
                        byte_cnt_d = '0;
                        we_d       = 1'b1;
                        waddr_d    = 32'({word_idx_q, 2'b00});
                        wdata_d    = {in_data, asm_q};
                        state_d    = ST_WRITE;
                    end else begin
                        case (byte_cnt_q)
                            2'd0:    asm_d[7:0]   = in_data;
                            2'd1:    asm_d[15:8]  = in_data;
                            default: asm_d[23:16] = in_data;
                        endcase
                        byte_cnt_d = byte_cnt_q + 2'd1;
                    end
                end
            end

            ST_WRITE: begin
                if (last_word) begin
                    state_d = ST_DONE;
                end else begin
                    word_idx_d = word_idx_q + IDX_W'(1);
                    state_d    = ST_LOAD;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any load in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            len_q      <= '0;
            byte_cnt_q <= '0;
            word_idx_q <= '0;
            asm_q      <= '0;
            we_q       <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge value of the others, independent of statement order.
            state_q    <= state_d;
            len_q      <= len_d;
            byte_cnt_q <= byte_cnt_d;
            word_idx_q <= word_idx_d;
            asm_q      <= asm_d;
            we_q       <= we_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            err_q      <= err_d;
        end
    end

    // Status outputs decode directly from the registered state.
    assign in_ready = (state_q == ST_LOAD);
    assign busy     = (state_q != ST_IDLE);
    assign cpu_hold = (state_q != ST_IDLE);
    assign done     = (state_q == ST_DONE);
    assign we       = we_q;
    assign waddr    = waddr_q;
    assign wdata    = wdata_q;
    assign err      = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: basic load, backpressure, illegal
// lengths, error recovery, full depth, ignored start and mid-load reset.
module tb_imem_loader;

    localparam int DEPTH = 64;
    localparam int LEN_W = 7;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [LEN_W-1:0] len_words = '0;
    logic             in_valid = 1'b0;
    logic [7:0]       in_data = '0;
    logic             in_ready;
    logic             we;
    logic [31:0]      waddr;
    logic [31:0]      wdata;
    logic             busy;
    logic             done;
    logic             err;
    logic             cpu_hold;

    imem_loader #(.DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .len_words (len_words),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .we        (we),
        .waddr     (waddr),
        .wdata     (wdata),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .cpu_hold  (cpu_hold)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Write log captured on the falling edge; checks index it from a base.
    logic [31:0] log_addr [256];
    logic [31:0] log_data [256];
    int wr_n      = 0;
    int done_n    = 0;
    int rdy_in_wr = 0;

    always @(negedge clk) begin
        if (we) begin
            if (wr_n < 256) begin
                log_addr[wr_n] <= waddr;
                log_data[wr_n] <= wdata;
            end
            wr_n <= wr_n + 1;
            if (in_ready) rdy_in_wr <= rdy_in_wr + 1;
        end
        if (done) done_n <= done_n + 1;
    end

    logic [7:0] basic_bytes [8] = '{8'h13, 8'h00, 8'h00, 8'h00,
                                    8'hB3, 8'h00, 8'h50, 8'h00};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; returns at the falling edge after the handshake.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int t = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("byte_accept_timeout", 32'(t < 50), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic do_start(input logic [LEN_W-1:0] len);
        start     = 1'b1;
        len_words = len;
        @(negedge clk);
        start     = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int t = 0;
        while (busy && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk(tag, 32'(t < 100), 32'd1);
        @(negedge clk);
    endtask

    initial begin
        int base;
        int dbase;
        int rbase;

        // Reset state
        @(negedge clk);
        chk("rst_flags", 32'({in_ready, we, busy, done, err, cpu_hold}), 32'd0);
        chk("rst_waddr", waddr, 32'd0);
        chk("rst_wdata", wdata, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic load, in_valid held high
        base = wr_n; dbase = done_n; rbase = rdy_in_wr;
        do_start(7'd2);
        chk("basic_hold_up", 32'({busy, cpu_hold, in_ready}), 32'b111);
        for (int i = 0; i < 8; i++) begin
            send_byte(basic_bytes[i], 0);
            if (i == 3) chk("basic_first_we", 32'(we), 32'd1);
        end
        chk("basic_second_we", 32'(we), 32'd1);
        chk("basic_second_addr", waddr, 32'h4);
        @(negedge clk);
        chk("basic_done", 32'({done, cpu_hold}), 32'b11);
        @(negedge clk);
        chk("basic_release", 32'({done, cpu_hold, busy}), 32'b000);
        chk("basic_count", 32'(wr_n - base), 32'd2);
        chk("basic_addr0", log_addr[base], 32'h0);
        chk("basic_data0", log_data[base], 32'h0000_0013);
        chk("basic_addr1", log_addr[base+1], 32'h4);
        chk("basic_data1", log_data[base+1], 32'h0050_00B3);
        chk("basic_done_n", 32'(done_n - dbase), 32'd1);

        // Backpressure: 3 idle cycles between bytes
        base = wr_n; dbase = done_n; rbase = rdy_in_wr;
        do_start(7'd2);
        for (int i = 0; i < 8; i++) send_byte(basic_bytes[i], (i < 7) ? 3 : 0);
        wait_idle("bp_idle_timeout");
        chk("bp_count", 32'(wr_n - base), 32'd2);
        chk("bp_addr0", log_addr[base], 32'h0);
        chk("bp_data0", log_data[base], 32'h0000_0013);
        chk("bp_addr1", log_addr[base+1], 32'h4);
        chk("bp_data1", log_data[base+1], 32'h0050_00B3);
        chk("bp_ready_in_write", 32'(rdy_in_wr - rbase), 32'd0);
        chk("bp_done_n", 32'(done_n - dbase), 32'd1);

        // Illegal length 0
        do_start(7'd0);
        chk("len0_err", 32'(err), 32'd1);
        chk("len0_idle", 32'({busy, in_ready, cpu_hold}), 32'b000);
        @(negedge clk);
        chk("len0_ready_stays", 32'(in_ready), 32'd0);

        // Recovery: legal start clears err
        base = wr_n;
        do_start(7'd1);
        chk("recover_err_clear", 32'(err), 32'd0);
        chk("recover_ready", 32'(in_ready), 32'd1);
        send_byte(8'h78, 0); send_byte(8'h56, 0);
        send_byte(8'h34, 0); send_byte(8'h12, 0);
        wait_idle("recover_idle_timeout");
        chk("recover_count", 32'(wr_n - base), 32'd1);
        chk("recover_addr", log_addr[base], 32'h0);
        chk("recover_data", log_data[base], 32'h1234_5678);

        // Illegal length 65
        do_start(7'd65);
        chk("len65_err", 32'(err), 32'd1);
        chk("len65_busy", 32'(busy), 32'd0);

        // Full depth: 64 words, byte = index mod 256
        base = wr_n; dbase = done_n; rbase = rdy_in_wr;
        do_start(7'd64);
        chk("full_err_clear", 32'(err), 32'd0);
        for (int i = 0; i < 256; i++) send_byte(8'(i), 0);
        wait_idle("full_idle_timeout");
        chk("full_count", 32'(wr_n - base), 32'd64);
        chk("full_addr1", log_addr[base+1], 32'h4);
        chk("full_data1", log_data[base+1], 32'h0706_0504);
        chk("full_last_addr", log_addr[base+63], 32'hFC);
        chk("full_last_data", log_data[base+63], 32'hFFFE_FDFC);
        chk("full_done_n", 32'(done_n - dbase), 32'd1);
        chk("full_ready_in_write", 32'(rdy_in_wr - rbase), 32'd0);

        // start during a load is ignored
        base = wr_n;
        do_start(7'd3);
        for (int i = 0; i < 5; i++) send_byte(8'(8'h10 + i), 0);
        start = 1'b1; len_words = 7'd1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 5; i < 12; i++) send_byte(8'(8'h10 + i), 0);
        wait_idle("midstart_idle_timeout");
        chk("midstart_count", 32'(wr_n - base), 32'd3);
        chk("midstart_data0", log_data[base], 32'h1312_1110);
        chk("midstart_data1", log_data[base+1], 32'h1716_1514);
        chk("midstart_addr2", log_addr[base+2], 32'h8);
        chk("midstart_data2", log_data[base+2], 32'h1B1A_1918);
        chk("midstart_err", 32'(err), 32'd0);

        // Reset after 6 bytes of a 2-word load
        do_start(7'd2);
        for (int i = 0; i < 6; i++) send_byte(8'(8'h20 + i), 0);
        rst_n = 1'b0;
        #1;
        chk("midrst_flags", 32'({in_ready, we, busy, done, err, cpu_hold}), 32'd0);
        chk("midrst_waddr", waddr, 32'd0);
        chk("midrst_wdata", wdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        base = wr_n;
        do_start(7'd1);
        send_byte(8'h33, 0); send_byte(8'h00, 0);
        send_byte(8'h00, 0); send_byte(8'h00, 0);
        wait_idle("postrst_idle_timeout");
        chk("postrst_count", 32'(wr_n - base), 32'd1);
        chk("postrst_addr", log_addr[base], 32'h0);
        chk("postrst_data", log_data[base], 32'h0000_0033);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
